// File: rtl/clk_div_gen.sv
// Programmable two-output divided clock generator with lock emulation.
// Outputs are gated until locked; accepting a new divisor pair relocks.
module clk_div_gen #(
  parameter int WIDTH        = 16,
  parameter int LOCK_CYCLES  = 16,
  parameter int DIV0_DEFAULT = 2,
  parameter int DIV1_DEFAULT = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div0,
  input  logic [WIDTH-1:0] cfg_div1,
  output logic             cfg_err,
  output logic             clkout0,
  output logic             clkout1,
  output logic             tick0,
  output logic             tick1,
  output logic             locked
);

  localparam int LW =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {
    LOCKING,
    LOCKED
  } state_t;

  state_t           state;
  logic [LW-1:0]    lock_cnt;
  logic [WIDTH-1:0] div0;
  logic [WIDTH-1:0] div1;
  logic [WIDTH-1:0] cnt0;
  logic [WIDTH-1:0] cnt1;

  logic             accept;
  logic             clamp;
  logic [WIDTH-1:0] new_div0;
  logic [WIDTH-1:0] new_div1;

  always_comb begin
    accept   = cfg_valid & cfg_ready;
    clamp    = (cfg_div0 < TWO) | (cfg_div1 < TWO);
    new_div0 = (cfg_div0 < TWO) ? TWO : cfg_div0;
    new_div1 = (cfg_div1 < TWO) ? TWO : cfg_div1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= LOCKING;
      lock_cnt  <= '0;
      div0      <= WIDTH'(DIV0_DEFAULT);
      div1      <= WIDTH'(DIV1_DEFAULT);
      cnt0      <= '0;
      cnt1      <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      clkout0   <= 1'b0;
      clkout1   <= 1'b0;
      tick0     <= 1'b0;
      tick1     <= 1'b0;
    end else begin
      cfg_err <= accept & clamp;
      if (accept) begin
        // Both counters restart from zero, phase-aligning the outputs
        state     <= LOCKING;
        lock_cnt  <= '0;
        div0      <= new_div0;
        div1      <= new_div1;
        cnt0      <= '0;
        cnt1      <= '0;
        locked    <= 1'b0;
        cfg_ready <= 1'b0;
        clkout0   <= 1'b0;
        clkout1   <= 1'b0;
        tick0     <= 1'b0;
        tick1     <= 1'b0;
      end else begin
        unique case (state)
          LOCKING: begin
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            clkout0   <= 1'b0;
            clkout1   <= 1'b0;
            tick0     <= 1'b0;
            tick1     <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
            if (lock_cnt == LOCK_LAST) begin
              state <= LOCKED;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          LOCKED: begin
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
            clkout0   <= cnt0 < (div0 >> 1);
            clkout1   <= cnt1 < (div1 >> 1);
            tick0     <= cnt0 == '0;
            tick1     <= cnt1 == '0;
            cnt0 <= (cnt0 == div0 - ONE) ? '0 : cnt0 + ONE;
            cnt1 <= (cnt1 == div1 - ONE) ? '0 : cnt1 + ONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: timeline reference model of lock start and
// divided-output phase, directed scenarios plus random traffic.
module tb_clk_div_gen;

  localparam int WIDTH = 16;
  localparam int LC    = 16;

  logic             clk_in;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div0;
  logic [WIDTH-1:0] cfg_div1;
  logic             cfg_err;
  logic             clkout0;
  logic             clkout1;
  logic             tick0;
  logic             tick1;
  logic             locked;

  clk_div_gen #(
    .WIDTH(WIDTH),
    .LOCK_CYCLES(LC),
    .DIV0_DEFAULT(2),
    .DIV1_DEFAULT(4)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div0(cfg_div0),
    .cfg_div1(cfg_div1),
    .cfg_err(cfg_err),
    .clkout0(clkout0),
    .clkout1(clkout1),
    .tick0(tick0),
    .tick1(tick1),
    .locked(locked)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks   = 0;
  int failures = 0;

  // Model: outputs run from cycle m_start on, phase = (cycle - start) % div
  int   cyc     = 0;
  int   m_start = 1 << 30;
  int   md0     = 2;
  int   md1     = 4;
  logic m_err   = 1'b0;
  logic m_ready = 1'b0;
  logic [6:0] m_exp = '0;

  logic [6:0] got;
  assign got = {locked, cfg_ready, cfg_err,
                clkout0, clkout1, tick0, tick1};

  task automatic step(input logic r, input logic v,
                      input int d0, input int d1);
    logic lk, c0, c1, t0, t1;
    int p0, p1;
    reset     = r;
    cfg_valid = v;
    cfg_div0  = WIDTH'(d0);
    cfg_div1  = WIDTH'(d1);
    @(posedge clk_in);
    if (r) begin
      m_start = cyc + 1 + LC;
      md0 = 2;
      md1 = 4;
      m_err = 1'b0;
    end else if (v && m_ready) begin
      m_err = (d0 < 2) || (d1 < 2);
      md0 = (d0 < 2) ? 2 : d0;
      md1 = (d1 < 2) ? 2 : d1;
      m_start = cyc + 1 + LC;
    end else begin
      m_err = 1'b0;
    end
    lk = 0; c0 = 0; c1 = 0; t0 = 0; t1 = 0;
    if (cyc >= m_start) begin
      p0 = (cyc - m_start) % md0;
      p1 = (cyc - m_start) % md1;
      lk = 1;
      c0 = p0 < md0 / 2;
      c1 = p1 < md1 / 2;
      t0 = p0 == 0;
      t1 = p1 == 0;
    end
    m_exp = {lk, lk, m_err, c0, c1, t0, t1};
    m_ready = lk;
    cyc++;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      if (got !== 7'b0) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b",
                 cyc, got, 7'b0);
      end
      checks++;
    end
  endtask

  task automatic test_defaults;
    int rise = -1;
    for (int i = 0; i < 48; i++) begin
      step(0, 0, 0, 0);
      if (locked === 1'b1 && rise < 0) rise = i;
      if (got !== m_exp) begin
        failures++;
        $display("FAIL defaults cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
    if (rise != LC) begin
      failures++;
      $display("FAIL lock_latency got=%0d exp=%0d", rise, LC);
    end
    checks++;
  endtask

  task automatic test_reconfig;
    step(0, 1, 5, 3);
    if (got !== m_exp) begin
      failures++;
      $display("FAIL reconfig_accept cyc=%0d got=%b exp=%b",
               cyc, got, m_exp);
    end
    checks++;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, 0);
      if (got !== m_exp) begin
        failures++;
        $display("FAIL reconfig cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
  endtask

  task automatic test_illegal;
    int errs = 0;
    step(0, 1, 0, 1);
    if (cfg_err === 1'b1) errs++;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0);
      if (cfg_err === 1'b1) errs++;
      if (got !== m_exp) begin
        failures++;
        $display("FAIL illegal cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
    if (errs != 1) begin
      failures++;
      $display("FAIL cfg_err_count got=%0d exp=1", errs);
    end
    checks++;
  endtask

  task automatic test_cfg_during_locking;
    int drop = -1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, 1, 8, 4);
      if (i > LC && locked === 1'b0 && drop < 0) drop = i;
      if (got !== m_exp) begin
        failures++;
        $display("FAIL lock_hold cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
    if (drop != LC + 1) begin
      failures++;
      $display("FAIL held_accept got=%0d exp=%0d", drop, LC + 1);
    end
    checks++;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0);
      if (got !== m_exp) begin
        failures++;
        $display("FAIL lock_hold_run cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
  endtask

  task automatic test_mid_reset;
    step(0, 1, 5, 4);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset cyc=%0d got=%b exp=%b",
               cyc, got, 7'b0);
    end
    checks++;
    for (int i = 0; i < 45; i++) begin
      step(0, 0, 0, 0);
      if (got !== m_exp) begin
        failures++;
        $display("FAIL mid_reset_run cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
  endtask

  task automatic test_reset_and_accept;
    for (int i = 0; i < 40 && !m_ready; i++) step(0, 0, 0, 0);
    step(1, 1, 7, 7);
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL rst_accept cyc=%0d got=%b exp=%b",
               cyc, got, 7'b0);
    end
    checks++;
    for (int i = 0; i < 45; i++) begin
      step(0, 0, 0, 0);
      if (got !== m_exp) begin
        failures++;
        $display("FAIL rst_accept_run cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
  endtask

  task automatic test_random;
    logic r, v;
    int d0, d1;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 11) == 0);
      d0 = $urandom_range(0, 13);
      d1 = $urandom_range(0, 13);
      step(r, v, d0, d1);
      if (got !== m_exp) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b",
                 cyc, got, m_exp);
      end
      checks++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_div0  = '0;
    cfg_div1  = '0;
    test_reset;
    test_defaults;
    test_reconfig;
    test_illegal;
    test_cfg_during_locking;
    test_mid_reset;
    test_reset_and_accept;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
